// File: rtl/mem_acc_ctrl.sv
// MEM-stage data access sequencer: drives the EX/MEM access onto a req/ack data bus,
// stalls the pipeline while outstanding, steers store lanes, aligns loads and flags exceptions.
module mem_acc_ctrl #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        cpurst,
   input  logic        ex2mem_mem_en_ffout,
   input  logic        ex2mem_wr_mem_ffout,
   input  logic [31:0] ex2mem_memaddr_ffout,
   input  logic [31:0] ex2mem_wr_memwdata_ffout,
   input  logic [2:0]  ex2mem_mem_op_ffout,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_err,
   output logic        memacc_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_rdata_vld,
   output logic        mem_exp,
   output logic [4:0]  mem_causecode,
   output logic [31:0] mem_mtval
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [4:0] CNT_LIM = 5'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [2:0]  op_q;
   logic        we_q, mis_q, flt_q;

   // Size decode on op[1:0]: 00 byte, 01 half, anything else word (covers 011/110/111).
   logic        is_b, is_h, misaligned;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [1:0]  a_lo;

   assign a_lo       = ex2mem_memaddr_ffout[1:0];
   assign is_b       = (ex2mem_mem_op_ffout[1:0] == 2'b00);
   assign is_h       = (ex2mem_mem_op_ffout[1:0] == 2'b01);
   assign misaligned = is_h ? a_lo[0] : (!is_b && (a_lo != 2'b00));

   always_comb begin
      be_n    = 4'hF;
      wdata_n = ex2mem_wr_memwdata_ffout;
      if (is_b) begin
         be_n    = 4'b0001 << a_lo;
         wdata_n = {4{ex2mem_wr_memwdata_ffout[7:0]}};
      end else if (is_h) begin
         be_n    = 4'b0011 << {a_lo[1], 1'b0};
         wdata_n = {2{ex2mem_wr_memwdata_ffout[15:0]}};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ex2mem_mem_en_ffout) state_d = misaligned ? DONE : REQ;
         REQ:     if (dbus_ack || (cnt_q == CNT_LIM)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cpurst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         op_q    <= '0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (ex2mem_mem_en_ffout) begin
                  addr_q  <= ex2mem_memaddr_ffout;
                  wdata_q <= wdata_n;
                  be_q    <= be_n;
                  op_q    <= ex2mem_mem_op_ffout;
                  we_q    <= ex2mem_wr_mem_ffout;
                  mis_q   <= misaligned;
                  flt_q   <= 1'b0;
               end
            end
            REQ: begin
               cnt_q <= cnt_q + 5'd1;
               // Ack wins over the timeout when both land in the same cycle.
               if (dbus_ack) begin
                  rdata_q <= dbus_rdata;
                  flt_q   <= dbus_err;
               end else if (cnt_q == CNT_LIM) begin
                  flt_q   <= 1'b1;
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   logic        done, exc;
   logic [31:0] sh, ld;

   assign done = (state_q == DONE);
   assign exc  = mis_q | flt_q;
   assign sh   = rdata_q >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (op_q)
         3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ld = {24'b0, sh[7:0]};
         3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ld = {16'b0, sh[15:0]};
         default: ld = sh;
      endcase
   end

   assign dbus_req      = (state_q == REQ);
   assign dbus_we       = we_q;
   assign dbus_addr     = {addr_q[31:2], 2'b00};
   assign dbus_wdata    = wdata_q;
   assign dbus_be       = be_q;
   assign memacc_stall  = ((state_q == IDLE) && ex2mem_mem_en_ffout) || (state_q == REQ);
   assign mem_exp       = done && exc;
   assign mem_rdata_vld = done && !exc && !we_q;
   assign mem_rdata     = mem_rdata_vld ? ld : 32'h0;
   // 4/6 misaligned, 5/7 fault; bit 1 selects store.
   assign mem_causecode = mem_exp ? {3'b001, we_q, !mis_q} : 5'd0;
   assign mem_mtval     = mem_exp ? addr_q : 32'h0;

endmodule

// File: tb/tb_mem_acc_ctrl.sv
// Self-checking bench for mem_acc_ctrl: transaction-level model sets per-cycle expectations,
// a negedge compare process checks them, plus literal checks on the documented examples.
module tb_mem_acc_ctrl;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        cpurst;
   logic        mem_en, wr_mem;
   logic [31:0] memaddr, wdata_in;
   logic [2:0]  mem_op;
   logic        dbus_req, dbus_we, dbus_ack, dbus_err;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic        memacc_stall, mem_rdata_vld, mem_exp;
   logic [31:0] mem_rdata, mem_mtval;
   logic [4:0]  mem_causecode;

   always #5 clk = ~clk;

   mem_acc_ctrl #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .cpurst(cpurst),
      .ex2mem_mem_en_ffout(mem_en), .ex2mem_wr_mem_ffout(wr_mem),
      .ex2mem_memaddr_ffout(memaddr), .ex2mem_wr_memwdata_ffout(wdata_in),
      .ex2mem_mem_op_ffout(mem_op),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ack(dbus_ack),
      .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
      .memacc_stall(memacc_stall), .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld),
      .mem_exp(mem_exp), .mem_causecode(mem_causecode), .mem_mtval(mem_mtval)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, written by the driver just after posedge.
   logic        chk_en = 1'b0;
   logic        e_req, e_stall, e_exp, e_vld, e_we;
   logic [31:0] e_addr, e_wdata, e_rdata, e_mtval;
   logic [3:0]  e_be;
   logic [4:0]  e_cause;

   // Observed history used by the literal checks.
   int          n_req, n_stall;
   logic [31:0] last_rdata, last_mtval, last_wdata;
   logic [4:0]  last_cause;
   logic [3:0]  last_be;
   logic        last_we;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dbus_req", dbus_req, e_req);
         chk("memacc_stall", memacc_stall, e_stall);
         chk("mem_exp", mem_exp, e_exp);
         chk("mem_rdata_vld", mem_rdata_vld, e_vld);
         if (e_req) begin
            chk("dbus_addr", dbus_addr, e_addr);
            chk("dbus_we", dbus_we, e_we);
            chk("dbus_be", dbus_be, e_be);
            if (e_we) chk("dbus_wdata", dbus_wdata, e_wdata);
         end
         if (e_vld) chk("mem_rdata", mem_rdata, e_rdata);
         if (e_exp) begin
            chk("mem_causecode", mem_causecode, e_cause);
            chk("mem_mtval", mem_mtval, e_mtval);
         end
         n_req   += int'(dbus_req);
         n_stall += int'(memacc_stall);
         if (dbus_req) begin
            last_be = dbus_be; last_wdata = dbus_wdata; last_we = dbus_we;
         end
         if (mem_rdata_vld) last_rdata = mem_rdata;
         if (mem_exp) begin
            last_cause = mem_causecode; last_mtval = mem_mtval;
         end
      end
   end

   // ---------------- behavioural model ----------------
   function automatic int size_of(input logic [2:0] op);
      case (op)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
      return (a % size_of(op)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
      int s;
      s = size_of(op);
      if (s == 4) return 4'hF;
      return 4'(((1 << s) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
      case (size_of(op))
         1:       return (wd & 32'hFF) * 32'h01010101;
         2:       return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] v;
      longint      x;
      v = rd >> (8 * (a % 4));
      case (op)
         3'b000: begin x = v & 32'hFF;   if (x >= 128)   x -= 256;   return 32'(x); end
         3'b001: begin x = v & 32'hFFFF; if (x >= 32768) x -= 65536; return 32'(x); end
         3'b100:  return v & 32'hFF;
         3'b101:  return v & 32'hFFFF;
         default: return v;
      endcase
   endfunction

   task automatic set_idle_exp();
      e_req = 0; e_stall = 0; e_exp = 0; e_vld = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mem_en = 0;
         dbus_ack = 1'($urandom); dbus_err = 1'($urandom); dbus_rdata = $urandom;
         memaddr = $urandom; mem_op = 3'($urandom);
         set_idle_exp();
         step();
      end
      dbus_ack = 0;
   endtask

   // ack_at: REQ cycle (1..T) carrying the ack, anything else means no ack.
   task automatic run_txn(input bit we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_at, input bit err);
      bit mis, fault;
      n_req = 0; n_stall = 0;
      last_rdata = '0; last_cause = '0; last_mtval = '0;
      mem_en = 1; wr_mem = we; mem_op = op; memaddr = addr; wdata_in = wd;
      dbus_ack = 1'($urandom); dbus_err = 1'($urandom); dbus_rdata = $urandom;
      set_idle_exp(); e_stall = 1;
      step();
      mis = is_mis(op, addr);
      fault = 0;
      if (!mis) begin
         for (int k = 1; k <= T; k++) begin
            e_req = 1; e_stall = 1; e_we = we;
            e_addr = addr & ~32'h3; e_be = m_be(op, addr); e_wdata = m_wdata(op, wd);
            if (k == ack_at) begin
               dbus_ack = 1; dbus_rdata = rd; dbus_err = err;
            end else begin
               dbus_ack = 0; dbus_rdata = $urandom; dbus_err = 1'($urandom);
            end
            step();
            if (k == ack_at) break;
         end
         fault = (ack_at < 1) || (ack_at > T) || err;
      end
      dbus_ack = 0;
      e_req = 0; e_stall = 0;
      e_exp = mis || fault;
      e_vld = !e_exp && !we;
      e_rdata = m_load(op, addr, rd);
      e_cause = mis ? (we ? 5'd6 : 5'd4) : (we ? 5'd7 : 5'd5);
      e_mtval = addr;
      step();
      mem_en = 0;
      set_idle_exp();
   endtask

   initial begin
      cpurst = 1; mem_en = 0; wr_mem = 0; memaddr = '0; wdata_in = '0; mem_op = '0;
      dbus_ack = 0; dbus_rdata = '0; dbus_err = 0;
      set_idle_exp();
      repeat (3) @(posedge clk);
      #1 cpurst = 0;
      @(negedge clk);
      chk("rst dbus_req", dbus_req, 0);
      chk("rst stall", memacc_stall, 0);
      chk("rst dbus_addr", dbus_addr, 0);
      chk("rst dbus_be", dbus_be, 0);
      chk("rst dbus_wdata", dbus_wdata, 0);
      chk("rst mem_exp", mem_exp, 0);
      chk("rst cause", mem_causecode, 0);
      chk("rst vld", mem_rdata_vld, 0);
      @(posedge clk); #1;
      chk_en = 1;

      // LW 0x100, ack on third REQ cycle
      run_txn(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0);
      chk("lw req cycles", n_req, 3);
      chk("lw stall cycles", n_stall, 4);
      chk("lw rdata", last_rdata, 32'hDEADBEEF);
      run_txn(0, 3'b000, 32'h103, 0, 32'h80123456, 1, 0);
      chk("lb rdata", last_rdata, 32'hFFFFFF80);
      chk("lb stall cycles", n_stall, 2);
      run_txn(0, 3'b100, 32'h103, 0, 32'h80123456, 2, 0);
      chk("lbu rdata", last_rdata, 32'h00000080);
      run_txn(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1, 0);
      chk("sh be", last_be, 4'b1100);
      chk("sh wdata", last_wdata, 32'hABCDABCD);
      chk("sh we", last_we, 1);
      run_txn(0, 3'b101, 32'h102, 0, 32'hABCD0000, 1, 0);
      chk("lhu rdata", last_rdata, 32'h0000ABCD);
      run_txn(0, 3'b010, 32'h102, 0, 0, 1, 0);
      chk("lw mis req cycles", n_req, 0);
      chk("lw mis stall", n_stall, 1);
      chk("lw mis cause", last_cause, 4);
      chk("lw mis mtval", last_mtval, 32'h102);
      run_txn(1, 3'b010, 32'h101, 32'h55, 0, 1, 0);
      chk("sw mis cause", last_cause, 6);
      run_txn(1, 3'b010, 32'h200, 32'h77, 0, 0, 0);
      chk("sw timeout req", n_req, T);
      chk("sw timeout cause", last_cause, 7);
      run_txn(0, 3'b010, 32'h204, 0, 32'h1, T, 0);
      chk("ack at limit rdata", last_rdata, 32'h1);
      run_txn(1, 3'b010, 32'h208, 32'h9, 0, 2, 1);
      chk("sw err cause", last_cause, 7);
      run_txn(0, 3'b001, 32'h20A, 0, 0, 1, 1);
      chk("lh err cause", last_cause, 5);
      chk("lh err mtval", last_mtval, 32'h20A);
      idle(2);

      // reset during second REQ cycle, ack one cycle late
      mem_en = 1; wr_mem = 0; mem_op = 3'b010; memaddr = 32'h300;
      set_idle_exp(); e_stall = 1;
      step();
      e_req = 1; e_addr = 32'h300; e_we = 0; e_be = 4'hF;
      step();
      cpurst = 1;
      step();
      cpurst = 0; mem_en = 0; dbus_ack = 1; dbus_rdata = 32'h1234;
      set_idle_exp();
      step();
      dbus_ack = 0;
      step();

      // back-to-back and randomized traffic
      run_txn(0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 1, 0);
      run_txn(0, 3'b010, 32'h404, 0, 32'h0BADF00D, 1, 0);
      chk("b2b lw stall", n_stall, 2);
      chk("b2b lw rdata", last_rdata, 32'h0BADF00D);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int          ack_at;
         a = $urandom;
         if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
         ack_at = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(T, 1));
         run_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom, ack_at,
                 $urandom_range(7, 0) == 0);
         idle(int'($urandom_range(2, 0)));
      end

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
